// File: rtl/add_later_pkg.sv
// rtl/add_later_pkg.sv - shared widths and pipeline stage record for add_later
package add_later_pkg;

    localparam int DATA_W_DEFAULT = 4;
    localparam int DIFF_W         = DATA_W_DEFAULT + 1;
    localparam int SUM_W          = DATA_W_DEFAULT + 2;

    typedef struct packed {
        logic                      valid;
        logic                      rangeErr;
        logic [DATA_W_DEFAULT-1:0] a;
    } stage_t;

endpackage

// File: rtl/add_later_stage.sv
// rtl/add_later_stage.sv - one pipeline stage register with shared advance enable
module add_later_stage
    import add_later_pkg::*;
#(
    parameter type T = stage_t
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    input  T     d,
    output T     q
);

    // Valid always shifts on advance; payload only follows a valid item so
    // bubbles leave the previous contents in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (adv) begin
            q.valid <= d.valid;
            if (d.valid) begin
                q.rangeErr <= d.rangeErr;
                q.a        <= d.a;
            end
        end
    end

endmodule

// File: rtl/add_later.sv
// rtl/add_later.sv - pipelined a = diff + b rebuild with stall handshake; optional ADD_LATER_ERRCNT_EN
module add_later
    import add_later_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validIn,
    output logic              readyOut,
    input  logic [DATA_W:0]   diffIn,
    input  logic [DATA_W-1:0] bIn,
    output logic              validOut,
    input  logic              readyIn,
    output logic [DATA_W-1:0] aOut,
    output logic              rangeErrOut
`ifdef ADD_LATER_ERRCNT_EN
    ,
    output logic [7:0]        errCountOut
`endif
);

    typedef struct packed {
        logic              valid;
        logic              rangeErr;
        logic [DATA_W-1:0] a;
    } stageW_t;

    logic [DATA_W+1:0] sum;
    logic              rangeErr;
    logic              adv;
    stageW_t           stg [LATENCY+1];

    // Both operands fit in DATA_W+1 bits, so the top bit flags a negative sum
    // and the next one flags an overflow past 2^DATA_W-1.
    assign sum      = {diffIn[DATA_W], diffIn} + {2'b00, bIn};
    assign rangeErr = sum[DATA_W+1] | sum[DATA_W];

    assign stg[0].valid    = validIn;
    assign stg[0].rangeErr = rangeErr;
    assign stg[0].a        = sum[DATA_W-1:0];

    genvar i;
    generate
        for (i = 0; i < LATENCY; i++) begin : g_stage
            add_later_stage #(
                .T (stageW_t)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .adv (adv),
                .d   (stg[i]),
                .q   (stg[i+1])
            );
        end
    endgenerate

    // Outputs read as idle while reset is held, before the registers clear.
    assign validOut    = stg[LATENCY].valid & ~rst;
    assign rangeErrOut = stg[LATENCY].rangeErr & ~rst;
    assign aOut        = rst ? '0 : stg[LATENCY].a;

    assign adv      = readyIn | ~validOut;
    assign readyOut = adv;

`ifdef ADD_LATER_ERRCNT_EN
    logic [7:0] errCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            errCnt <= '0;
        end else if (validOut && readyIn && rangeErrOut && (errCnt != 8'hFF)) begin
            errCnt <= errCnt + 8'd1;
        end
    end

    assign errCountOut = errCnt;
`endif

endmodule

// File: tb/tb_add_later.sv
// tb/tb_add_later.sv - randomized and directed checks of add_later at LATENCY 3, 1 and 8
module tb_add_later;

    localparam int LATS [3] = '{3, 1, 8};

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        validIn = 1'b0;
    logic        readyIn = 1'b1;
    logic [4:0]  diffIn  = '0;
    logic [3:0]  bIn     = '0;
    logic [2:0]  vO, rO, eO;
    logic [11:0] aAll;
`ifdef ADD_LATER_ERRCNT_EN
    logic [23:0] cAll;
`endif

    int vectors     = 0;
    int miscompares = 0;

    int       expQ [3][$];
    logic     stallPrev [3];
    logic [3:0] prevA [3];
    logic     prevE [3];
    int       errModel [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    add_later #(.LATENCY(3)) dut0 (
        .clk(clk), .rst(rst), .validIn(validIn), .readyOut(rO[0]),
        .diffIn(diffIn), .bIn(bIn), .validOut(vO[0]), .readyIn(readyIn),
        .aOut(aAll[3:0]), .rangeErrOut(eO[0])
`ifdef ADD_LATER_ERRCNT_EN
        , .errCountOut(cAll[7:0])
`endif
    );

    add_later #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .validIn(validIn), .readyOut(rO[1]),
        .diffIn(diffIn), .bIn(bIn), .validOut(vO[1]), .readyIn(readyIn),
        .aOut(aAll[7:4]), .rangeErrOut(eO[1])
`ifdef ADD_LATER_ERRCNT_EN
        , .errCountOut(cAll[15:8])
`endif
    );

    add_later #(.LATENCY(8)) dut2 (
        .clk(clk), .rst(rst), .validIn(validIn), .readyOut(rO[2]),
        .diffIn(diffIn), .bIn(bIn), .validOut(vO[2]), .readyIn(readyIn),
        .aOut(aAll[11:8]), .rangeErrOut(eO[2])
`ifdef ADD_LATER_ERRCNT_EN
        , .errCountOut(cAll[23:16])
`endif
    );

    // Reference: plain integer sum; bit 4 of the code is the range flag.
    function automatic int model(input logic [4:0] d, input logic [3:0] b);
        int s;
        s = int'($signed(d)) + int'(b);
        return (((s < 0) || (s > 15)) ? 16 : 0) + (s & 15);
    endfunction

    // Scoreboard: every accepted item must leave once, in order, with the right value.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                expQ[k].delete();
                stallPrev[k] = 1'b0;
                errModel[k]  = 0;
            end else begin
`ifdef ADD_LATER_ERRCNT_EN
                vectors++;
                if (cAll[k*8 +: 8] !== 8'(errModel[k])) begin
                    miscompares++;
                    $display("FAIL errcount dut%0d got %0d want %0d", k, cAll[k*8 +: 8], errModel[k]);
                end
`endif
                vectors++;
                if (rO[k] !== (readyIn | ~vO[k])) begin
                    miscompares++;
                    $display("FAIL readyOut dut%0d got %b want %b", k, rO[k], readyIn | ~vO[k]);
                end
                if (stallPrev[k]) begin
                    vectors++;
                    if (vO[k] !== 1'b1 || aAll[k*4 +: 4] !== prevA[k] || eO[k] !== prevE[k]) begin
                        miscompares++;
                        $display("FAIL hold dut%0d got v=%b a=%0d e=%b want v=1 a=%0d e=%b",
                                 k, vO[k], aAll[k*4 +: 4], eO[k], prevA[k], prevE[k]);
                    end
                end
                if (vO[k] && readyIn) begin
                    vectors++;
                    if (expQ[k].size() == 0) begin
                        miscompares++;
                        $display("FAIL extra_output dut%0d got a=%0d want none", k, aAll[k*4 +: 4]);
                    end else begin
                        int e;
                        e = expQ[k].pop_front();
                        if (aAll[k*4 +: 4] !== 4'(e & 15) || eO[k] !== ((e & 16) != 0)) begin
                            miscompares++;
                            $display("FAIL result dut%0d got a=%0d e=%b want a=%0d e=%b",
                                     k, aAll[k*4 +: 4], eO[k], e & 15, (e & 16) != 0);
                        end
                        if ((e & 16) != 0 && errModel[k] < 255) errModel[k]++;
                    end
                end
                if (validIn && rO[k]) expQ[k].push_back(model(diffIn, bIn));
                stallPrev[k] = vO[k] & ~readyIn;
                prevA[k]     = aAll[k*4 +: 4];
                prevE[k]     = eO[k];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        validIn = 1'b0;
        readyIn = 1'b1;
        rst     = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        validIn = 1'b1;
        diffIn  = 5'd4;
        bIn     = 4'd6;
        tick();
        tick();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (vO[k] !== 1'b0 || aAll[k*4 +: 4] !== 4'd0 || eO[k] !== 1'b0 || rO[k] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL reset_state dut%0d phase%0d got v=%b a=%0d e=%b r=%b want 0 0 0 1",
                             k, p, vO[k], aAll[k*4 +: 4], eO[k], rO[k]);
                end
`ifdef ADD_LATER_ERRCNT_EN
                if (p == 1) begin
                    vectors++;
                    if (cAll[k*8 +: 8] !== 8'd0) begin
                        miscompares++;
                        $display("FAIL reset_errcount dut%0d got %0d want 0", k, cAll[k*8 +: 8]);
                    end
                end
`endif
            end
            rst     = 1'b0;
            validIn = 1'b0;
            #1;
        end
        idle(2);
    endtask

    task automatic test_stream;
        int dv [3] = '{4, -3, 0};
        int bv [3] = '{6, 8, 3};
        int ev [3] = '{10, 5, 3};
        int hA [3][4];
        int hE [3][4];
        int hC [3][4];
        int hN [3] = '{0, 0, 0};
        for (int c = 0; c < 15; c++) begin
            validIn = (c < 3);
            readyIn = 1'b1;
            if (c < 3) begin
                diffIn = 5'(dv[c]);
                bIn    = 4'(bv[c]);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                if (vO[k] && readyIn && hN[k] < 4) begin
                    hA[k][hN[k]] = int'(aAll[k*4 +: 4]);
                    hE[k][hN[k]] = int'(eO[k]);
                    hC[k][hN[k]] = c;
                    hN[k]++;
                end
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (hN[k] != 3) begin
                miscompares++;
                $display("FAIL stream_count dut%0d got %0d want 3", k, hN[k]);
            end else begin
                for (int j = 0; j < 3; j++) begin
                    vectors++;
                    if (hA[k][j] != ev[j] || hE[k][j] != 0 || hC[k][j] != LATS[k] + j) begin
                        miscompares++;
                        $display("FAIL stream_item dut%0d #%0d got a=%0d e=%0d cyc=%0d want a=%0d e=0 cyc=%0d",
                                 k, j, hA[k][j], hE[k][j], hC[k][j], ev[j], LATS[k] + j);
                    end
                end
            end
        end
        idle(3);
    endtask

    task automatic test_stall;
        int dv [3] = '{4, -3, 0};
        int bv [3] = '{6, 8, 3};
        int ev [3] = '{10, 5, 3};
        int hA [4];
        int hN = 0;
        for (int c = 0; c < 12; c++) begin
            validIn = (c < 3);
            readyIn = !(c == 3 || c == 4);
            if (c < 3) begin
                diffIn = 5'(dv[c]);
                bIn    = 4'(bv[c]);
            end
            #1;
            if (c == 3 || c == 4) begin
                vectors++;
                if (vO[0] !== 1'b1 || aAll[3:0] !== 4'd10 || rO[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc%0d got v=%b a=%0d r=%b want v=1 a=10 r=0",
                             c, vO[0], aAll[3:0], rO[0]);
                end
            end
            if (vO[0] && readyIn && hN < 4) begin
                hA[hN] = int'(aAll[3:0]);
                hN++;
            end
            tick();
        end
        vectors++;
        if (hN != 3) begin
            miscompares++;
            $display("FAIL stall_count got %0d want 3", hN);
        end else begin
            for (int j = 0; j < 3; j++) begin
                vectors++;
                if (hA[j] != ev[j]) begin
                    miscompares++;
                    $display("FAIL stall_order #%0d got %0d want %0d", j, hA[j], ev[j]);
                end
            end
        end
        idle(10);
    endtask

    task automatic test_range;
        int dv [3] = '{15, -16, -1};
        int bv [3] = '{15, 0, 1};
        int ea [3] = '{14, 0, 0};
        int ee [3] = '{1, 1, 0};
        int hA [4];
        int hE [4];
        int hN = 0;
        for (int c = 0; c < 10; c++) begin
            validIn = (c < 3);
            readyIn = 1'b1;
            if (c < 3) begin
                diffIn = 5'(dv[c]);
                bIn    = 4'(bv[c]);
            end
            #1;
            if (vO[0] && hN < 4) begin
                hA[hN] = int'(aAll[3:0]);
                hE[hN] = int'(eO[0]);
                hN++;
            end
            tick();
        end
        vectors++;
        if (hN != 3) begin
            miscompares++;
            $display("FAIL range_count got %0d want 3", hN);
        end else begin
            for (int j = 0; j < 3; j++) begin
                vectors++;
                if (hA[j] != ea[j] || hE[j] != ee[j]) begin
                    miscompares++;
                    $display("FAIL range #%0d got a=%0d e=%0d want a=%0d e=%0d", j, hA[j], hE[j], ea[j], ee[j]);
                end
            end
        end
        idle(10);
    endtask

    task automatic test_midreset;
        int hA [3][4];
        int hC [3][4];
        int hN [3] = '{0, 0, 0};
        for (int c = 0; c < 16; c++) begin
            rst     = (c == 2);
            validIn = (c == 0 || c == 1 || c == 4);
            readyIn = 1'b1;
            case (c)
                0:       begin diffIn = 5'd4;      bIn = 4'd6; end
                1:       begin diffIn = 5'(-3);    bIn = 4'd8; end
                default: begin diffIn = 5'd2;      bIn = 4'd2; end
            endcase
            #1;
            if (c == 3) begin
                for (int k = 0; k < 3; k++) begin
                    vectors++;
                    if (vO[k] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL midreset_flush dut%0d got v=%b want 0", k, vO[k]);
                    end
                end
            end
            if (c >= 3) begin
                for (int k = 0; k < 3; k++) begin
                    if (vO[k] && hN[k] < 4) begin
                        hA[k][hN[k]] = int'(aAll[k*4 +: 4]);
                        hC[k][hN[k]] = c;
                        hN[k]++;
                    end
                end
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (hN[k] != 1 || hA[k][0] != 4 || hC[k][0] != 4 + LATS[k]) begin
                miscompares++;
                $display("FAIL midreset_fresh dut%0d got n=%0d a=%0d cyc=%0d want n=1 a=4 cyc=%0d",
                         k, hN[k], hA[k][0], hC[k][0], 4 + LATS[k]);
            end
        end
        idle(3);
    endtask

    task automatic test_random;
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom_range(0, 149) == 0);
            validIn = ($urandom_range(0, 9) < 7);
            readyIn = ($urandom_range(0, 9) < 7);
            diffIn  = 5'($urandom);
            bIn     = 4'($urandom);
            tick();
        end
        idle(12);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (expQ[k].size() != 0) begin
                miscompares++;
                $display("FAIL random_drain dut%0d got %0d pending want 0", k, expQ[k].size());
            end
        end
    endtask

`ifdef ADD_LATER_ERRCNT_EN
    task automatic test_errcnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            validIn = (c == 0);
            readyIn = !(c >= 3 && c <= 7);
            diffIn  = 5'd15;
            bIn     = 4'd15;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (cAll[k*8 +: 8] !== 8'd1) begin
                miscompares++;
                $display("FAIL errcnt_once dut%0d got %0d want 1", k, cAll[k*8 +: 8]);
            end
        end
        validIn = 1'b1;
        readyIn = 1'b1;
        for (int c = 0; c < 300; c++) tick();
        idle(12);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (cAll[k*8 +: 8] !== 8'd255) begin
                miscompares++;
                $display("FAIL errcnt_sat dut%0d got %0d want 255", k, cAll[k*8 +: 8]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_range();
        test_midreset();
        test_random();
`ifdef ADD_LATER_ERRCNT_EN
        test_errcnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
